// File: rtl/mult_sched_pkg.sv
// Shared types for the round-robin multiplier scheduler.
// Holds the controller state encoding and the result value used for aborted jobs.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_A,
    ISSUE_B,
    WAIT,
    FLUSH,
    RESP
  } state_t;

  // Result reported for a job aborted by the watchdog.
  localparam int ZERO_RESULT = 0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin arbiter: the search starts just after the last winner (ptr)
// and wraps, returning a one-hot grant, its index and whether anything was requesting.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  // NOTE: every output gets a default before the search loop, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int off = 1; off <= N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one strobe-handshake multiplier among N_REQ requesters: round-robin grant,
// a-then-b operand issue, result return to the owner and a watchdog flush of a hung multiplier.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [W-1:0]             resp_z,
  output logic                     resp_err,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  output logic                     mul_a_stb,
  output logic                     mul_b_stb,
  input  logic [W-1:0]             mul_z,
  input  logic                     mul_z_stb,
  output logic                     mul_rst
);

  localparam int IW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT);

  state_t         state, state_nx;
  logic [IW-1:0]  ptr;
  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic [W-1:0]   z_q;
  logic           err_q;
  logic [WDW-1:0] wdog;
  logic           wdog_expired;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign wdog_expired = (wdog == WDW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any) state_nx = ISSUE_A;
      ISSUE_A: state_nx = ISSUE_B;
      ISSUE_B: state_nx = WAIT;
      // A result arriving on the last watchdog cycle still wins over the flush.
      WAIT:    if (mul_z_stb) state_nx = RESP;
               else if (wdog_expired) state_nx = FLUSH;
      FLUSH:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-high, so it appears only inside the clocked
  // branch; all state uses non-blocking assignments to avoid ordering races between blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= IW'(N_REQ - 1);
      grant_id    <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      z_q         <= '0;
      err_q       <= 1'b0;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (pick_any) begin
            mul_a    <= req_a[int'(pick_idx)*W +: W];
            mul_b    <= req_b[int'(pick_idx)*W +: W];
            grant_id <= pick_idx;
            z_q      <= '0;
            err_q    <= 1'b0;
          end
        end
        ISSUE_B: wdog <= '0;
        WAIT: begin
          wdog <= wdog + WDW'(1);
          if (mul_z_stb) z_q <= mul_z;
        end
        FLUSH: begin
          timeout_err <= 1'b1;
          z_q         <= W'(ZERO_RESULT);
          err_q       <= 1'b1;
        end
        RESP:    ptr <= grant_id;
        default: ;
      endcase
    end
  end

  // Handshake outputs are suppressed while rst is high so an abandoned job never completes.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_z     = '0;
    resp_err   = 1'b0;
    mul_a_stb  = 1'b0;
    mul_b_stb  = 1'b0;
    if (!rst) begin
      if (state == IDLE) req_ready = pick_grant;
      mul_a_stb = (state == ISSUE_A);
      mul_b_stb = (state == ISSUE_B);
      if (state == RESP) begin
        resp_valid[grant_id] = 1'b1;
        resp_z               = z_q;
        resp_err             = err_q;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign mul_rst = rst | (state == FLUSH);

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench: stub multiplier (z = a ^ b after stub_lat cycles, 0 = never) and a
// behavioural round-robin / latency / watchdog model driving randomized and directed jobs.
module tb_mult_rr_scheduler;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 64;
  localparam int IW      = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     resp_valid;
  logic [W-1:0]     resp_z;
  logic             resp_err;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic             timeout_err;
  logic [W-1:0]     mul_a, mul_b;
  logic             mul_a_stb, mul_b_stb;
  logic [W-1:0]     mul_z = '0;
  logic             mul_z_stb = 1'b0;
  logic             mul_rst;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: last granted requester and sticky watchdog flag.
  int   m_ptr  = N - 1;
  logic m_terr = 1'b0;

  // Stub multiplier state.
  int         stub_lat = 1;
  int         stub_cnt = 0;
  logic [W-1:0] stub_a = '0, stub_b = '0;

  mult_rr_scheduler #(.N_REQ(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_z      (resp_z),
    .resp_err    (resp_err),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_a_stb   (mul_a_stb),
    .mul_b_stb   (mul_b_stb),
    .mul_z       (mul_z),
    .mul_z_stb   (mul_z_stb),
    .mul_rst     (mul_rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mul_z_stb <= 1'b0;
    if (mul_rst) begin
      stub_cnt <= 0;
    end else begin
      if (mul_a_stb) stub_a <= mul_a;
      if (mul_b_stb) begin
        stub_b   <= mul_b;
        stub_cnt <= stub_lat;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          mul_z_stb <= 1'b1;
          mul_z     <= stub_a ^ stub_b;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] m, input int p);
    for (int off = 1; off <= N; off++) begin
      int k;
      k = (p + off) % N;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  // One complete job: called at a negedge with the DUT idle.
  task automatic run_job(input logic [N-1:0] mask, input int lat,
                         input bit fixed, input logic [W-1:0] fa, input logic [W-1:0] fb);
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    int           w, exp_c, resp_c, rst_c, n_mrst;
    bit           got, timed_out;
    logic [N-1:0] cap_lane;
    logic [W-1:0] cap_z;
    logic         cap_err;

    for (int i = 0; i < N; i++) begin
      a[i] = fixed ? fa : W'($urandom);
      b[i] = fixed ? fb : W'($urandom);
      req_a[i*W +: W] = a[i];
      req_b[i*W +: W] = b[i];
    end
    w         = model_pick(mask, m_ptr);
    timed_out = (lat < 1 || lat > TIMEOUT - 1);
    exp_c     = timed_out ? TIMEOUT + 1 : lat + 1;
    stub_lat  = lat;
    req_valid = mask;
    #1;
    check("req_ready", req_ready, N'(1) << w);

    @(negedge clk);
    req_valid = '0;
    check("a_stb", {mul_a_stb, mul_b_stb}, 2'b10);
    check("mul_a", mul_a, a[w]);
    check("grant_id", grant_id, w);

    @(negedge clk);
    check("b_stb", {mul_a_stb, mul_b_stb}, 2'b01);
    check("mul_b", mul_b, b[w]);

    got = 0; resp_c = -1; rst_c = -1; n_mrst = 0;
    cap_lane = '0; cap_z = '0; cap_err = 1'b0;
    for (int c = 0; c < TIMEOUT + 8 && !got; c++) begin
      @(negedge clk);
      if (mul_rst) begin
        n_mrst++;
        rst_c = c;
      end
      if (resp_valid != '0) begin
        got      = 1;
        resp_c   = c;
        cap_lane = resp_valid;
        cap_z    = resp_z;
        cap_err  = resp_err;
      end
    end
    check("resp_seen", got, 1'b1);
    check("resp_latency", resp_c, exp_c);
    check("resp_lane", cap_lane, N'(1) << w);
    check("resp_z", cap_z, timed_out ? W'(0) : (a[w] ^ b[w]));
    check("resp_err", cap_err, timed_out);
    check("mul_rst_pulses", n_mrst, timed_out ? 1 : 0);
    if (timed_out) check("flush_cycle", rst_c, TIMEOUT);
    if (timed_out) m_terr = 1'b1;
    check("timeout_err", timeout_err, m_terr);

    @(negedge clk);
    check("idle_after_resp", {busy, resp_valid}, '0);
    m_ptr = w;
  endtask

  initial begin
    logic [N-1:0] seq [10];

    req_valid = '1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {req_ready, resp_valid, busy, timeout_err, grant_id, mul_a_stb, mul_b_stb},
          '0);
    check("rst_mul_rst", mul_rst, 1'b1);
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("post_rst", {mul_rst, busy, req_ready}, '0);

    // Nothing requesting: controller must stay idle.
    repeat (2) @(negedge clk);
    check("idle_no_req", {busy, req_ready, mul_a_stb}, '0);

    run_job(4'b0001, 8, 1'b1, 8'h30, 8'h40);

    // Directed fairness sequence (all-valid rotation, then wrap cases).
    seq = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
            4'b0010, 4'b1001, 4'b1001, 4'b1000, 4'b1010};
    for (int i = 0; i < 10; i++) run_job(seq[i], $urandom_range(1, 10), 1'b0, '0, '0);

    // Result strobe exactly on the last watchdog cycle: normal completion.
    run_job(4'b0100, TIMEOUT - 1, 1'b0, '0, '0);
    // Multiplier never answers: watchdog flush.
    run_job(4'b0100, 0, 1'b0, '0, '0);
    // The flag is sticky across later good jobs.
    run_job(4'b0011, 3, 1'b0, '0, '0);

    // Reset in the middle of WAIT abandons the job.
    begin
      int stray;
      stub_lat  = 0;
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_mul_rst", mul_rst, 1'b1);
      check("mid_rst_no_resp", resp_valid, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_state", {busy, timeout_err, grant_id}, '0);
      stray = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (resp_valid != '0 || busy) stray++;
      end
      check("mid_rst_quiet", stray, 0);
      m_ptr  = N - 1;
      m_terr = 1'b0;
    end
    run_job(4'b1011, 5, 1'b0, '0, '0);

    // Randomized traffic.
    for (int i = 0; i < 30; i++)
      run_job(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(1, 12), 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
